// File: rtl/ext_sd_pkg.sv
// Shared types and constants for the ext SD card SPI engine.
// The state enum is shared so the engine and any debug taps agree on its encoding.
package ext_sd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOW,
      HIGH,
      DONE
   } spi_state_t;

   localparam int         SPI_BITS          = 8;
   localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/sd_spi_clk_div.sv
// Loadable down-counter that paces SCLK half-periods for the SD SPI engine.
// The terminal-count flag is high while the count sits at zero.
module sd_spi_clk_div (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_load,
   input  logic       i_en,
   input  logic [7:0] i_loadVal,
   output logic       o_tc
);

   logic [7:0] r_count;

   // Load takes priority; counting stops at zero so an idle phase never wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 8'd0;
      end else if (i_load) begin
         r_count <= i_loadVal;
      end else if (i_en && (r_count != 8'd0)) begin
         r_count <= r_count - 8'd1;
      end
   end

   assign o_tc = (r_count == 8'd0);

endmodule

// File: rtl/ext_sd_spi_engine.sv
// Turns single-cycle mapper byte requests into 8-bit SPI mode-0 transfers to the SD card.
// Every transfer is full duplex; the received byte is published when busy drops.
module ext_sd_spi_engine
   import ext_sd_pkg::*;
#(
   parameter int         CLK_DIV   = 4,
   parameter logic [7:0] IDLE_BYTE = DEFAULT_IDLE_BYTE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx,
   input  logic       rx,
   input  logic [7:0] data_to_SD,
   input  logic       cs_sel,
   output logic [7:0] data_from_SD,
   output logic       busy,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
   localparam logic [2:0] BIT_RELOAD = 3'(SPI_BITS - 1);

   spi_state_t r_state;
   spi_state_t w_nextState;

   logic [7:0] r_shift;
   logic [7:0] r_dataFromSd;
   logic [2:0] r_bitCnt;
   logic       r_misoBit;
   logic       r_sclk;
   logic       r_mosi;
   logic       r_csN;
   logic       r_busy;

   logic       w_req;
   logic       w_divLoad;
   logic       w_divEn;
   logic       w_divTc;

   assign w_req = tx | rx;

   sd_spi_clk_div u_clkDiv (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_divLoad),
      .i_en      (w_divEn),
      .i_loadVal (DIV_RELOAD),
      .o_tc      (w_divTc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_divLoad   = 1'b0;
      w_divEn     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req) begin
               w_divLoad   = 1'b1;
               w_nextState = LOW;
            end
         end
         LOW: begin
            w_divEn = 1'b1;
            if (w_divTc) begin
               w_divLoad   = 1'b1;
               w_nextState = HIGH;
            end
         end
         HIGH: begin
            w_divEn = 1'b1;
            if (w_divTc) begin
               if (r_bitCnt == 3'd0) begin
                  w_nextState = DONE;
               end else begin
                  w_divLoad   = 1'b1;
                  w_nextState = LOW;
               end
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // MISO is captured on the rising SCLK edge and merged into the shifter on
   // the falling edge, so the outgoing MSB stays intact for the whole bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shift      <= 8'd0;
         r_dataFromSd <= 8'hFF;
         r_bitCnt     <= 3'd0;
         r_misoBit    <= 1'b0;
         r_sclk       <= 1'b0;
         r_mosi       <= 1'b1;
         r_csN        <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_csN <= ~cs_sel;
               if (tx) begin
                  r_shift  <= data_to_SD;
                  r_mosi   <= data_to_SD[7];
                  r_bitCnt <= BIT_RELOAD;
                  r_busy   <= 1'b1;
               end else if (rx) begin
                  r_shift  <= IDLE_BYTE;
                  r_mosi   <= IDLE_BYTE[7];
                  r_bitCnt <= BIT_RELOAD;
                  r_busy   <= 1'b1;
               end
            end
            LOW: begin
               if (w_divTc) begin
                  r_misoBit <= spi_miso;
                  r_sclk    <= 1'b1;
               end
            end
            HIGH: begin
               if (w_divTc) begin
                  r_sclk  <= 1'b0;
                  r_shift <= {r_shift[6:0], r_misoBit};
                  if (r_bitCnt != 3'd0) begin
                     r_mosi   <= r_shift[6];
                     r_bitCnt <= r_bitCnt - 3'd1;
                  end
               end
            end
            DONE: begin
               r_dataFromSd <= r_shift;
               r_mosi       <= 1'b1;
               r_busy       <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign data_from_SD = r_dataFromSd;
   assign busy         = r_busy;
   assign spi_sclk     = r_sclk;
   assign spi_mosi     = r_mosi;
   assign spi_cs_n     = r_csN;

endmodule

// File: tb/tb_ext_sd_spi_engine.sv
// Randomized self-checking bench for ext_sd_spi_engine with a card-side MISO model
// and a transfer-level reference model of the expected SPI traffic.
module tb_ext_sd_spi_engine;

   localparam int TB_DIV = 4;

   logic       clk;
   logic       reset_n;
   logic       tx;
   logic       rx;
   logic [7:0] data_to_SD;
   logic       cs_sel;
   logic [7:0] data_from_SD;
   logic       busy;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_cs_n;

   logic [7:0] misoShift;
   logic [7:0] expData;
   int         checks;
   int         failures;

   ext_sd_spi_engine #(.CLK_DIV(TB_DIV), .IDLE_BYTE(8'hFF)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tx           (tx),
      .rx           (rx),
      .data_to_SD   (data_to_SD),
      .cs_sel       (cs_sel),
      .data_from_SD (data_from_SD),
      .busy         (busy),
      .spi_sclk     (spi_sclk),
      .spi_mosi     (spi_mosi),
      .spi_miso     (spi_miso),
      .spi_cs_n     (spi_cs_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Card model: presents its byte MSB first and advances on each falling SCLK.
   assign spi_miso = misoShift[7];
   always @(negedge spi_sclk) misoShift <= {misoShift[6:0], 1'b1};

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
      end
   endtask

   // Issues one request and follows the whole transfer, comparing SPI traffic and
   // timing against what an 8-bit mode-0 exchange at TB_DIV must look like.
   task automatic applyStimulus(input logic useTx, input logic useRx, input logic [7:0] txByte,
                                input logic [7:0] misoByte, input int extraTxAt, input int csDropAt);
      int         busyCycles;
      int         highCycles;
      int         pulses;
      int         run;
      int         badWidths;
      int         csBad;
      logic       prevSclk;
      logic       finished;
      logic [7:0] mosiCap;
      logic [7:0] expMosi;
      misoShift  = misoByte;
      expMosi    = useTx ? txByte : 8'hFF;
      @(negedge clk);
      tx         = useTx;
      rx         = useRx;
      data_to_SD = txByte;
      @(negedge clk);
      tx         = 1'b0;
      rx         = 1'b0;
      data_to_SD = 8'($urandom);
      checkOutput("busyRise", 32'(busy), 32'd1);
      busyCycles = 1;
      highCycles = 0;
      pulses     = 0;
      run        = 0;
      badWidths  = 0;
      csBad      = 0;
      prevSclk   = spi_sclk;
      finished   = 1'b0;
      mosiCap    = 8'd0;
      for (int c = 1; c < 16 * TB_DIV + 50; c++) begin
         @(negedge clk);
         tx = (c == extraTxAt);
         if (c == csDropAt) cs_sel = 1'b0;
         if (!busy) begin
            finished = 1'b1;
            break;
         end
         busyCycles++;
         if (csDropAt >= 0 && spi_cs_n !== 1'b0) csBad++;
         if (spi_sclk) begin
            highCycles++;
            run++;
            if (!prevSclk) begin
               pulses++;
               mosiCap = {mosiCap[6:0], spi_mosi};
            end
         end else if (prevSclk) begin
            if (run != TB_DIV) badWidths++;
            run = 0;
         end
         prevSclk = spi_sclk;
      end
      tx = 1'b0;
      checkOutput("transferTimeout", 32'(finished), 32'd1);
      checkOutput("busyLength", 32'(busyCycles), 32'(16 * TB_DIV + 1));
      checkOutput("sclkPulses", 32'(pulses), 32'd8);
      checkOutput("sclkHighCycles", 32'(highCycles), 32'(8 * TB_DIV));
      checkOutput("sclkPulseWidth", 32'(badWidths), 32'd0);
      checkOutput("mosiByte", 32'(mosiCap), 32'(expMosi));
      expData = misoByte;
      checkOutput("dataFromSd", 32'(data_from_SD), 32'(expData));
      checkOutput("mosiIdle", 32'(spi_mosi), 32'd1);
      checkOutput("sclkIdle", 32'(spi_sclk), 32'd0);
      if (csDropAt >= 0) begin
         checkOutput("csHeldDuringBusy", 32'(csBad), 32'd0);
         checkOutput("csHeldFirstIdle", 32'(spi_cs_n), 32'd0);
         @(negedge clk);
         checkOutput("csReleased", 32'(spi_cs_n), 32'd1);
      end
   endtask

   initial begin
      int pulses;
      int busySeen;
      logic hit;
      checks     = 0;
      failures   = 0;
      tx         = 1'b0;
      rx         = 1'b0;
      data_to_SD = 8'd0;
      cs_sel     = 1'b0;
      misoShift  = 8'hFF;
      expData    = 8'hFF;
      reset_n    = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;

      repeat (50) @(negedge clk);
      checkOutput("rstCsN", 32'(spi_cs_n), 32'd1);
      checkOutput("rstSclk", 32'(spi_sclk), 32'd0);
      checkOutput("rstMosi", 32'(spi_mosi), 32'd1);
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstData", 32'(data_from_SD), 32'hFF);

      cs_sel = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("csSelect", 32'(spi_cs_n), 32'd0);

      // Abort a transfer with reset during its fifth SCLK pulse.
      misoShift = 8'h5A;
      rx = 1'b1;
      @(negedge clk);
      rx = 1'b0;
      pulses = 0;
      hit = 1'b0;
      for (int c = 0; c < 16 * TB_DIV + 20; c++) begin
         @(negedge clk);
         if (spi_sclk && !hit) begin
            pulses++;
            hit = 1'b1;
         end else if (!spi_sclk) begin
            hit = 1'b0;
         end
         if (pulses == 5) break;
      end
      checkOutput("reachedPulse5", 32'(pulses), 32'd5);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("abortSclk", 32'(spi_sclk), 32'd0);
      checkOutput("abortMosi", 32'(spi_mosi), 32'd1);
      checkOutput("abortCsN", 32'(spi_cs_n), 32'd1);
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortData", 32'(data_from_SD), 32'hFF);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      applyStimulus(1'b0, 1'b1, 8'h00, 8'h01, -1, -1);
      applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C, -1, -1);

      // Simultaneous tx/rx, plus a request while busy that must be dropped.
      applyStimulus(1'b1, 1'b1, 8'h40, 8'($urandom), 10, -1);
      busySeen = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy) busySeen++;
      end
      checkOutput("droppedRequest", 32'(busySeen), 32'd0);

      for (int n = 0; n < 20; n++) begin
         int kind;
         kind = int'($urandom_range(0, 2));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         applyStimulus(kind != 1, kind != 0, 8'($urandom), 8'($urandom), -1, -1);
      end

      applyStimulus(1'b1, 1'b0, 8'($urandom), 8'($urandom), 30, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ext_sd_spi_engine.md
Name: ext_sd_spi_engine

Overview:
- Serves the byte-level requests a cartridge mapper issues on the ext SD card interface (`tx`, `rx`, `data_to_SD`).
- Converts each request into an 8-bit SPI mode-0 transfer to the physical SD card.
- Returns the received byte and a busy flag to the mapper.
- Sits between the mapper instance (e.g. the MFRSD mapper) and the SD card pins in the peripheral tree.

Parameters:
- CLK_DIV, 4: `clk` cycles per SCLK half-period; legal range 2..255.
- IDLE_BYTE, 8'hFF: byte shifted out on MOSI during an `rx`-only request.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx  in  1  single-cycle strobe: send `data_to_SD`
- rx  in  1  single-cycle strobe: read a byte, sending IDLE_BYTE
- data_to_SD  in  8  byte to transmit, sampled with `tx`
- cs_sel  in  1  card select request from mapper register (1 = selected)
- data_from_SD  out  8  last byte received from the card
- busy  out  1  transfer in progress
- spi_sclk  out  1  SPI clock, idle low
- spi_mosi  out  1  SPI data to card, MSB first
- spi_miso  in  1  SPI data from card (pre-synchronised externally)
- spi_cs_n  out  1  card chip select, active low

Behaviour:
- Reset (async, `reset_n` = 0), all outputs take these values:
  - `spi_sclk` = 0
  - `spi_mosi` = 1
  - `spi_cs_n` = 1
  - `busy` = 0
  - `data_from_SD` = 8'hFF
  - FSM = IDLE; divider and bit counters = 0
- Reset asserted mid-transfer aborts immediately with the same values; no partial byte is written to `data_from_SD`.
- `spi_cs_n` is `~cs_sel`, registered (one cycle latency). It is updated only in IDLE; a `cs_sel` change while busy takes effect the cycle after the FSM returns to IDLE.
- FSM states: IDLE, LOW, HIGH, DONE.
- IDLE:
  - `tx` = 1: load shift register with `data_to_SD`.
  - else `rx` = 1: load shift register with IDLE_BYTE.
  - `tx` and `rx` both high in the same cycle: `tx` wins, and the byte is still captured.
  - On either request: `busy` goes to 1 next cycle, `spi_mosi` takes the shift register MSB, bit counter = 7, divider = CLK_DIV-1, go to LOW.
- LOW:
  - `spi_sclk` = 0; divider counts down.
  - At divider = 0: sample `spi_miso` into the shift register LSB side, set `spi_sclk` = 1, reload divider, go to HIGH.
- HIGH:
  - `spi_sclk` = 1; divider counts down.
  - At divider = 0: set `spi_sclk` = 0.
    - If bit counter = 0: go to DONE.
    - Else: shift left, put the new MSB on `spi_mosi`, decrement bit counter, reload divider, go to LOW.
- DONE (one cycle): `data_from_SD` <= shift register, `spi_mosi` = 1, `busy` = 0 next cycle, go to IDLE.
- Timing:
  - Request to `busy` rising: 1 cycle.
  - `busy` high for exactly 16*CLK_DIV+1 cycles.
  - `data_from_SD` valid on the first cycle `busy` = 0.
- Transfers are always full duplex: a `tx` transfer also updates `data_from_SD`.
- Requests while `busy` = 1 are ignored (dropped, not queued). The mapper must poll `busy`.
- Back-to-back: a request in the first IDLE cycle after DONE is accepted, giving a minimum 1-cycle gap between transfers.
- The divider counter is 8 bits wide; the bit counter is 3 bits and wraps only via the explicit reload.

Decomposition:
- Package ext_sd_pkg holds:
  - typedef enum logic [1:0] spi_state_t {IDLE, LOW, HIGH, DONE}
  - localparam SPI_BITS = 8
  - the default IDLE_BYTE constant
- One natural sub-module: sd_spi_clk_div (loadable down-counter, terminal-count pulse).
- The shifter and FSM stay in the top module.

Test Plan:
- Reset, then release with no stimulus -> `spi_cs_n` = 1, `spi_sclk` = 0, `spi_mosi` = 1, `busy` = 0, `data_from_SD` = 8'hFF held indefinitely.
- `cs_sel` = 1, `tx` with `data_to_SD` = 8'hA5, MISO model returning 8'h3C, CLK_DIV = 4 -> MOSI bits 1,0,1,0,0,1,0,1 at rising edges; 8 SCLK pulses each 4 cycles high/4 low; `busy` high 65 cycles; `data_from_SD` = 8'h3C.
- `rx` with MISO model returning 8'h01 -> MOSI constant 1 for all 8 bits; `data_from_SD` = 8'h01 when `busy` falls.
- `tx`(8'h40) and `rx` in the same cycle, then a second `tx` pulse 10 cycles later while busy -> exactly one 8'h40 transfer (8 SCLK pulses); the second request is dropped.
- `reset_n` pulsed low at SCLK pulse 5 of a transfer -> outputs take reset values within the same cycle; `data_from_SD` remains its pre-transfer value of 8'hFF; the next `rx` completes normally.
- `cs_sel` toggled 1->0 mid-transfer -> `spi_cs_n` stays 0 until 1 cycle after `busy` falls, then goes to 1.
